// File: rtl/vslice_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vslice_pkg
//  Description : Shared definitions for the vslice address sequencer.
//                Default widths, the sequencer state encoding and the
//                command descriptor layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package vslice_pkg;

  // Default widths. The sequencer drives one port of a 2K-word DPRAM.
  localparam int VSLICE_ADDR_W = 11;
  localparam int VSLICE_DATA_W = 32;
  localparam int VSLICE_LEN_W  = 12;  // holds 0..2048 beats

  // Two-state burst sequencer.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  // Command descriptor as presented on the cmd_* inputs.
  typedef struct packed {
    logic [VSLICE_ADDR_W-1:0] base;
    logic [VSLICE_ADDR_W-1:0] stride;
    logic [VSLICE_LEN_W-1:0]  len;
    logic                     we;
  } cmd_t;

endpackage : vslice_pkg
`default_nettype wire

// File: rtl/vslice_addr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : vslice_addr_seq
//  Description : Strided burst address sequencer. Accepts a burst command
//                (base, stride, length, direction) and issues one request
//                per beat to a downstream DPRAM port, honouring
//                backpressure from the port and, for writes, gaps in the
//                write-data stream.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, srst                 clock, synchronous active-high reset
//    cmd_valid / cmd_ready     command handshake
//    cmd_base / cmd_stride     first word address / per-beat increment
//    cmd_len / cmd_we          beat count (0..2048) / 1 = write burst
//    wd_valid/wd_ready/wd_data write-data stream (write bursts only)
//    t_addr/t_data/t_we/t_valid/t_ready  request to the DPRAM port
//    busy                      burst in progress
//    done                      one-cycle pulse after the last beat
//    stall_cnt                 cycles with t_valid & !t_ready
//
//  Build option
//    VSLICE_SEQ_STALL_CNT_EN   when defined, stall_cnt is a saturating
//                              backpressure counter cleared only by srst;
//                              otherwise it is tied to zero.
// ============================================================================
module vslice_addr_seq
  import vslice_pkg::*;
#(
  parameter int ADDR_W = VSLICE_ADDR_W,
  parameter int DATA_W = VSLICE_DATA_W,
  parameter int LEN_W  = VSLICE_LEN_W
) (
  input  logic              clk,
  input  logic              srst,
  // command
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_stride,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_we,
  // write data
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  // DPRAM port request
  output logic [ADDR_W-1:0] t_addr,
  output logic [DATA_W-1:0] t_data,
  output logic              t_we,
  output logic              t_valid,
  input  logic              t_ready,
  // status
  output logic              busy,
  output logic              done,
  output logic [31:0]       stall_cnt
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              we_q, we_d;
  logic              done_q, done_d;

  logic              run;
  logic              cmd_fire;
  logic              beat;

  // Outputs are forced to their reset values while srst is high, so the
  // port is quiet even in the cycle before the reset edge lands.
  assign run       = (state_q == RUN) && !srst;
  assign cmd_ready = (state_q == IDLE) && !srst;
  assign busy      = run;
  assign done      = done_q && !srst;

  // A read beat is always ready to go; a write beat needs its data word.
  assign t_valid   = run && (!we_q || wd_valid);
  assign wd_ready  = run && we_q && t_ready;
  assign t_addr    = srst ? '0 : addr_q;
  assign t_we      = we_q && !srst;
  assign t_data    = wd_data;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign beat      = t_valid && t_ready;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    rem_d    = rem_q;
    we_d     = we_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_len == '0) begin
            // Empty burst: nothing to issue, just acknowledge completion.
            done_d = 1'b1;
          end else begin
            addr_d   = cmd_base;
            stride_d = cmd_stride;
            rem_d    = cmd_len;
            we_d     = cmd_we;
            state_d  = RUN;
          end
        end
      end

      RUN: begin
        if (beat) begin
          // Address wraps modulo 2^ADDR_W by natural truncation.
          addr_d = addr_q + stride_q;
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      rem_q    <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      rem_q    <= rem_d;
      we_q     <= we_d;
      done_q   <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Backpressure counter
  // --------------------------------------------------------------------------
`ifdef VSLICE_SEQ_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    // Saturate rather than wrap so a long-running count never looks small.
    if (t_valid && !t_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = srst ? 32'd0 : stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule : vslice_addr_seq
`default_nettype wire

// File: tb/tb_vslice_addr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vslice_addr_seq
//  Description : Scoreboard bench for vslice_addr_seq. Commands push their
//                expected beat list (address, direction, data) and done
//                timing into queues; a negedge monitor compares every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vslice_addr_seq;
  import vslice_pkg::*;

  localparam int AW   = VSLICE_ADDR_W;
  localparam int DW   = VSLICE_DATA_W;
  localparam int LW   = VSLICE_LEN_W;
  localparam int AMOD = 1 << AW;
`ifdef VSLICE_SEQ_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] data;
    bit            last;
  } beat_t;

  logic          clk = 1'b0;
  logic          srst;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_base, cmd_stride;
  logic [LW-1:0] cmd_len;
  logic          cmd_we;
  logic          wd_valid, wd_ready;
  logic [DW-1:0] wd_data;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_data;
  logic          t_we, t_valid, t_ready;
  logic          busy, done;
  logic [31:0]   stall_cnt;

  vslice_addr_seq dut (
    .clk        (clk),
    .srst       (srst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_base   (cmd_base),
    .cmd_stride (cmd_stride),
    .cmd_len    (cmd_len),
    .cmd_we     (cmd_we),
    .wd_valid   (wd_valid),
    .wd_ready   (wd_ready),
    .wd_data    (wd_data),
    .t_addr     (t_addr),
    .t_data     (t_data),
    .t_we       (t_we),
    .t_valid    (t_valid),
    .t_ready    (t_ready),
    .busy       (busy),
    .done       (done),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  beat_t         beat_q[$];
  int            done_q[$];
  logic [DW-1:0] wq[$];      // write words still to be offered
  bit            pat_q[$];   // forced wd_valid pattern
  bit            rdy_mode;   // 1: t_ready always high, 0: random
  bit            wd_mode;    // 1: wd_valid always high, 0: random
  int            rdy_low;    // forced t_ready-low cycles
  logic [31:0]   exp_stall;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic cmd_t mk(input int b, input int s, input int l, input bit w);
    cmd_t c;
    c.base   = AW'(b);
    c.stride = AW'(s);
    c.len    = LW'(l);
    c.we     = w;
    return c;
  endfunction

  // Present a command, wait for acceptance, then record what must follow.
  task automatic send_cmd(input cmd_t c);
    int    n = 0;
    beat_t b;
    cmd_base   = c.base;
    cmd_stride = c.stride;
    cmd_len    = c.len;
    cmd_we     = c.we;
    cmd_valid  = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL cmd_accept_timeout: actual=cmd_ready 0 required=1 cyc=%0d", cyc);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < int'(c.len); i++) begin
      b.addr = AW'((int'(c.base) + i * int'(c.stride)) % AMOD);
      b.we   = c.we;
      b.data = c.we ? DW'($urandom) : '0;
      b.last = (i == int'(c.len) - 1);
      beat_q.push_back(b);
      if (c.we) wq.push_back(b.data);
    end
    if (c.len == '0) done_q.push_back(cyc);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((beat_q.size() != 0 || done_q.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: actual=%0d beats pending required=0", beat_q.size());
      beat_q.delete();
      done_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Downstream-port and write-data source
  initial begin
    t_ready  = 1'b0;
    wd_valid = 1'b0;
    wd_data  = '0;
    forever begin
      @(negedge clk);
      if (!srst && wd_valid && wd_ready && wq.size() > 0) void'(wq.pop_front());
      @(posedge clk);
      #2;
      if (srst) begin
        wq.delete();
        pat_q.delete();
      end
      if (rdy_low > 0) begin
        t_ready = 1'b0;
        rdy_low--;
      end else if (rdy_mode) begin
        t_ready = 1'b1;
      end else begin
        t_ready = ($urandom_range(0, 3) != 0);
      end
      if (wq.size() == 0) begin
        wd_valid = 1'b0;
        wd_data  = DW'($urandom);
      end else begin
        wd_data = wq[0];
        if (pat_q.size() > 0)  wd_valid = pat_q.pop_front();
        else if (wd_mode)      wd_valid = 1'b1;
        else                   wd_valid = ($urandom_range(0, 2) != 0);
      end
    end
  end

  // Monitor
  initial begin
    beat_t mb;
    bit    pend, tv_exp, exp_done;
    forever begin
      @(negedge clk);
      if (srst) begin
        chk("rst_t_valid",   32'(t_valid),   32'd0);
        chk("rst_wd_ready",  32'(wd_ready),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_t_addr",    32'(t_addr),    32'd0);
        chk("rst_t_we",      32'(t_we),      32'd0);
        chk("rst_stall_cnt", stall_cnt,      32'd0);
        beat_q.delete();
        done_q.delete();
        exp_stall = '0;
      end else begin
        pend   = (beat_q.size() != 0);
        tv_exp = 1'b0;
        chk("busy",      32'(busy),      32'(pend));
        chk("cmd_ready", 32'(cmd_ready), 32'(!pend));
        if (pend) begin
          mb     = beat_q[0];
          tv_exp = !mb.we || wd_valid;
          chk("t_valid",  32'(t_valid),  32'(tv_exp));
          chk("t_addr",   32'(t_addr),   32'(mb.addr));
          chk("t_we",     32'(t_we),     32'(mb.we));
          chk("wd_ready", 32'(wd_ready), 32'(mb.we && t_ready));
          if (mb.we && tv_exp) chk("t_data", t_data, mb.data);
        end else begin
          chk("idle_t_valid",  32'(t_valid),  32'd0);
          chk("idle_wd_ready", 32'(wd_ready), 32'd0);
        end
        exp_done = (done_q.size() != 0) && (done_q[0] == cyc);
        chk("done", 32'(done), 32'(exp_done));
        if (done_q.size() != 0 && done_q[0] <= cyc) void'(done_q.pop_front());
        chk("stall_cnt", stall_cnt, exp_stall);
        if (pend && tv_exp) begin
          if (!t_ready) begin
            if (STALL_EN && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
          end else begin
            void'(beat_q.pop_front());
            if (mb.last) done_q.push_back(cyc + 1);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    srst      = 1'b1;
    cmd_valid = 1'b0;
    cmd_base  = '0;
    cmd_stride = '0;
    cmd_len   = '0;
    cmd_we    = 1'b0;
    rdy_mode  = 1'b1;
    wd_mode   = 1'b1;
    rdy_low   = 0;
    exp_stall = '0;
    repeat (3) @(posedge clk);
    #1;
    srst = 1'b0;

    // Read, then address wrap
    send_cmd(mk('h010, 4, 4, 1'b0));
    wait_idle();
    send_cmd(mk('h7FE, 1, 4, 1'b0));
    wait_idle();

    // Zero-length command followed back-to-back by a short write
    send_cmd(mk('h123, 5, 0, 1'b0));
    send_cmd(mk('h050, 3, 2, 1'b1));
    wait_idle();

    // Write with a one-cycle data gap
    pat_q.push_back(1'b1);
    pat_q.push_back(1'b0);
    pat_q.push_back(1'b1);
    pat_q.push_back(1'b1);
    send_cmd(mk('h300, 8, 3, 1'b1));
    wait_idle();

    // Backpressure: five cycles of t_ready low after the first beat
    send_cmd(mk('h040, 1, 8, 1'b0));
    @(posedge clk);
    #1;
    rdy_low = 5;
    wait_idle();
    chk("bp_stall_total", stall_cnt, STALL_EN ? 32'd5 : 32'd0);

    // Reset during beat 2 of an 8-beat read, then a fresh command
    send_cmd(mk('h200, 2, 8, 1'b0));
    @(posedge clk);
    @(posedge clk);
    #1;
    srst = 1'b1;
    @(posedge clk);
    #1;
    srst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    send_cmd(mk('h100, 3, 5, 1'b0));
    wait_idle();

    // Randomised back-to-back traffic with random backpressure and gaps
    rdy_mode = 1'b0;
    wd_mode  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      int l;
      l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 16));
      send_cmd(mk(int'($urandom_range(0, AMOD - 1)), int'($urandom_range(0, AMOD - 1)),
                  l, 1'($urandom_range(0, 1))));
    end
    wait_idle();

    // Maximum-length write burst
    send_cmd(mk(int'($urandom_range(0, AMOD - 1)), int'($urandom_range(0, AMOD - 1)),
                2048, 1'b1));
    wait_idle();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: actual=still running required=finished checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_vslice_addr_seq
`default_nettype wire
